// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes, handshake FSM encodings and IRQ width
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_INI = 3'd0;
  localparam logic [2:0] ST_AW  = 3'd1;
  localparam logic [2:0] ST_W   = 3'd2;
  localparam logic [2:0] ST_AWW = 3'd3;
  localparam logic [2:0] ST_AR1 = 3'd4;
  localparam logic [2:0] ST_AR2 = 3'd5;

  localparam int IRQ_W = 8;

endpackage

// File: rtl/axil_slave_fsm.sv
// rtl/axil_slave_fsm.sv - AXI4-Lite slave handshake FSM with address/data latching
// and single-shot write commit / read capture strobes
module axil_slave_fsm
  import axil_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  output logic              wr_commit,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_capture
);

  logic [2:0] state;
  logic       committed;

  assign S_AXI_AWREADY = (state == ST_INI) || (state == ST_W);
  assign S_AXI_WREADY  = (state == ST_INI) || (state == ST_AW);
  assign S_AXI_ARREADY = (state == ST_INI);
  assign S_AXI_BVALID  = (state == ST_AWW);
  assign S_AXI_RVALID  = (state == ST_AR2);

  // committed is set from the second AWW cycle on, so a stalled BREADY never re-commits
  assign wr_commit  = (state == ST_AWW) && !committed;
  assign rd_capture = (state == ST_AR1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INI;
      committed <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_strb   <= '0;
      rd_addr   <= '0;
    end else begin
      committed <= (state == ST_AWW);
      case (state)
        ST_INI: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            wr_addr <= S_AXI_AWADDR;
            wr_data <= S_AXI_WDATA;
            wr_strb <= S_AXI_WSTRB;
            state   <= ST_AWW;
          end else if (S_AXI_AWVALID) begin
            wr_addr <= S_AXI_AWADDR;
            state   <= ST_AW;
          end else if (S_AXI_WVALID) begin
            wr_data <= S_AXI_WDATA;
            wr_strb <= S_AXI_WSTRB;
            state   <= ST_W;
          end else if (S_AXI_ARVALID) begin
            rd_addr <= S_AXI_ARADDR;
            state   <= ST_AR1;
          end
        end
        ST_AW: begin
          if (S_AXI_WVALID) begin
            wr_data <= S_AXI_WDATA;
            wr_strb <= S_AXI_WSTRB;
            state   <= ST_AWW;
          end
        end
        ST_W: begin
          if (S_AXI_AWVALID) begin
            wr_addr <= S_AXI_AWADDR;
            state   <= ST_AWW;
          end
        end
        ST_AWW:  if (S_AXI_BREADY) state <= ST_INI;
        ST_AR1:  state <= ST_AR2;
        ST_AR2:  if (S_AXI_RREADY) state <= ST_INI;
        default: state <= ST_INI;
      endcase
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - AXI4-Lite control/status register bank; define
// AXIL_REG_BANK_IRQ_EN to add the ISR (W1C) / IER interrupt registers
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                 NREG     = 4,
  parameter int                 NSTAT    = 4,
  parameter int                 ADDR_W   = 12,
  parameter logic [NREG*32-1:0] CTRL_RST = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [31:0]         S_AXI_WDATA,
  input  logic [3:0]          S_AXI_WSTRB,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [31:0]         S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [NREG*32-1:0]  ctrl_q,
  output logic [NREG-1:0]     ctrl_we,
  input  logic [NSTAT*32-1:0] stat_d,
  input  logic [IRQ_W-1:0]    irq_src,
  output logic                irq
);

  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_commit, rd_capture;
  logic [31:0]       widx, ridx;
  logic              wr_ok;
  logic [31:0]       rd_data_c;
  logic [1:0]        rd_resp_c;

  axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .wr_commit    (wr_commit),
    .rd_addr      (rd_addr),
    .rd_capture   (rd_capture)
  );

  assign widx = 32'(wr_addr[ADDR_W-1:2]);
  assign ridx = 32'(rd_addr[ADDR_W-1:2]);

  wire unused_addr_lsb = ^{wr_addr[1:0], rd_addr[1:0]};

`ifdef AXIL_REG_BANK_IRQ_EN
  localparam logic [31:0] ISR_IDX = 32'(NREG + NSTAT);
  localparam logic [31:0] IER_IDX = 32'(NREG + NSTAT + 1);

  logic [IRQ_W-1:0] isr_q, ier_q, isr_clr;
  logic             irq_q;

  assign isr_clr = (wr_commit && widx == ISR_IDX && wr_strb[0]) ? wr_data[IRQ_W-1:0] : '0;

  // Sources are OR-ed in after the clear so a coincident set survives the W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      isr_q <= '0;
      ier_q <= '0;
      irq_q <= 1'b0;
    end else begin
      isr_q <= (isr_q & ~isr_clr) | irq_src;
      if (wr_commit && widx == IER_IDX && wr_strb[0]) ier_q <= wr_data[IRQ_W-1:0];
      irq_q <= |(isr_q & ier_q);
    end
  end

  assign irq   = irq_q;
  assign wr_ok = (widx < 32'(NREG)) || (widx == ISR_IDX) || (widx == IER_IDX);
`else
  wire unused_irq_src = ^irq_src;

  assign irq   = 1'b0;
  assign wr_ok = (widx < 32'(NREG));
`endif

  // wr_addr only moves on a latch, so this decode is stable for the whole response
  assign S_AXI_BRESP = wr_ok ? RESP_OKAY : RESP_SLVERR;

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_SLVERR;
    for (int i = 0; i < NREG; i++) begin
      if (ridx == 32'(i)) begin
        rd_data_c = ctrl_q[32*i +: 32];
        rd_resp_c = RESP_OKAY;
      end
    end
    for (int j = 0; j < NSTAT; j++) begin
      if (ridx == 32'(NREG + j)) begin
        rd_data_c = stat_d[32*j +: 32];
        rd_resp_c = RESP_OKAY;
      end
    end
`ifdef AXIL_REG_BANK_IRQ_EN
    if (ridx == ISR_IDX) begin
      rd_data_c = 32'(isr_q);
      rd_resp_c = RESP_OKAY;
    end
    if (ridx == IER_IDX) begin
      rd_data_c = 32'(ier_q);
      rd_resp_c = RESP_OKAY;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q      <= CTRL_RST;
      ctrl_we     <= '0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      ctrl_we <= '0;
      for (int i = 0; i < NREG; i++) begin
        if (wr_commit && widx == 32'(i)) begin
          ctrl_we[i] <= 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) ctrl_q[32*i + 8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
      if (rd_capture) begin
        S_AXI_RDATA <= rd_data_c;
        S_AXI_RRESP <= rd_resp_c;
      end
    end
  end

endmodule
